// File: rtl/btb_pkg.sv
// Shared types for the BTB update path: write-request record and controller states.
package btb_pkg;
  localparam int ADDR_WIDTH = 6;
  localparam int PC_BITS    = 11;

  typedef struct packed {
    logic [PC_BITS-1:0] pc;
    logic [PC_BITS-1:0] target;
    logic               valid;
  } btb_wr_req_t;

  typedef enum logic {ST_CLEAR, ST_RUN} state_t;
endpackage

// File: rtl/btb_wr_fifo.sv
// Pending BTB write queue: synchronous FIFO, push and pop allowed in the same cycle.
module btb_wr_fifo
  import btb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        push,
  input  logic        pop,
  input  btb_wr_req_t din,
  output btb_wr_req_t dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);

  btb_wr_req_t    mem [DEPTH];
  logic [AW:0]    wr_ptr, rd_ptr;
  logic           do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  // a full queue still accepts when the head leaves on the same edge
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/btb_update_ctrl.sv
// Branch-resolution controller: mispredict redirect, queued BTB writes, and the
// invalidate sweep that owns the BTB write port after reset or flush.
module btb_update_ctrl #(
  parameter int ADDR_WIDTH = btb_pkg::ADDR_WIDTH,
  parameter int PC_BITS    = btb_pkg::PC_BITS,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               resolve_valid,
  input  logic [PC_BITS-1:0] resolve_pc,
  input  logic               resolve_taken,
  input  logic [PC_BITS-1:0] resolve_target,
  input  logic               pred_hit,
  input  logic [PC_BITS-1:0] pred_target,
  input  logic               flush_btb,
  output logic               redirect,
  output logic [PC_BITS-1:0] redirect_pc,
  output logic               btb_wr_en,
  output logic [PC_BITS-1:0] btb_wr_pc,
  output logic [PC_BITS-1:0] btb_wr_target,
  output logic               btb_wr_valid,
  output logic               busy,
  output logic [7:0]         drop_cnt
);
  import btb_pkg::*;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep_idx, sweep_ix;
  logic                  flush_run, mispredict, req_vld, do_pop, sweeping, drop;
  logic                  fifo_full, fifo_empty;
  btb_wr_req_t           req, head;

  assign mispredict = resolve_valid &&
                      (resolve_taken ? (!pred_hit || pred_target != resolve_target) : pred_hit);
  // flush is only honoured in RUN; an in-flight sweep is never restarted
  assign flush_run  = flush_btb && (state == ST_RUN);
  assign req_vld    = mispredict && !flush_run;
  assign do_pop     = (state == ST_RUN) && !flush_btb && !fifo_empty;
  assign drop       = req_vld && fifo_full && !do_pop && (drop_cnt != 8'hFF);
  assign sweeping   = (state == ST_CLEAR) || flush_run;
  // the flush edge itself issues index 0 so the sweep starts the very next cycle
  assign sweep_ix   = flush_run ? '0 : sweep_idx;

  always_comb begin
    req        = '0;
    req.pc     = resolve_pc;
    req.target = resolve_taken ? resolve_target : '0;
    req.valid  = resolve_taken;
  end

  btb_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (flush_run),
    .push  (req_vld),
    .pop   (do_pop),
    .din   (req),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_CLEAR;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (sweep_idx == '1) state_nxt = ST_RUN;
      ST_RUN:   if (flush_btb)       state_nxt = ST_CLEAR;
      default:                       state_nxt = ST_CLEAR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      redirect      <= 1'b0;
      redirect_pc   <= '0;
      btb_wr_en     <= 1'b0;
      btb_wr_pc     <= '0;
      btb_wr_target <= '0;
      btb_wr_valid  <= 1'b0;
      busy          <= 1'b1;
      drop_cnt      <= '0;
      sweep_idx     <= '0;
    end else begin
      redirect <= mispredict;
      if (mispredict)
        redirect_pc <= resolve_taken ? resolve_target : resolve_pc + PC_BITS'(1);
      if (sweeping) begin
        btb_wr_en     <= 1'b1;
        btb_wr_pc     <= {{(PC_BITS-ADDR_WIDTH){1'b0}}, sweep_ix};
        btb_wr_target <= '0;
        btb_wr_valid  <= 1'b0;
        busy          <= 1'b1;
        sweep_idx     <= sweep_ix + ADDR_WIDTH'(1);
      end else begin
        btb_wr_en     <= do_pop;
        btb_wr_pc     <= do_pop ? head.pc     : '0;
        btb_wr_target <= do_pop ? head.target : '0;
        btb_wr_valid  <= do_pop && head.valid;
        busy          <= 1'b0;
      end
      if (drop) drop_cnt <= drop_cnt + 8'd1;
    end
  end
endmodule

// File: tb/tb_btb_update_ctrl.sv
// Bench for btb_update_ctrl: vector table, hand sequences, and random traffic
// compared every cycle against a queue-based reference model.
module tb_btb_update_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        resolve_valid, resolve_taken, pred_hit, flush_btb;
  logic [10:0] resolve_pc, resolve_target, pred_target;
  logic        redirect, btb_wr_en, btb_wr_valid, busy;
  logic [10:0] redirect_pc, btb_wr_pc, btb_wr_target;
  logic [7:0]  drop_cnt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  btb_update_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .resolve_valid(resolve_valid), .resolve_pc(resolve_pc),
    .resolve_taken(resolve_taken), .resolve_target(resolve_target),
    .pred_hit(pred_hit), .pred_target(pred_target), .flush_btb(flush_btb),
    .redirect(redirect), .redirect_pc(redirect_pc),
    .btb_wr_en(btb_wr_en), .btb_wr_pc(btb_wr_pc), .btb_wr_target(btb_wr_target),
    .btb_wr_valid(btb_wr_valid), .busy(busy), .drop_cnt(drop_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [10:0] pc; logic [10:0] tgt; logic v; } wreq_t;
  wreq_t       pend[$];
  int          m_left, m_idx, m_drops;
  logic        m_redirect, m_busy, m_wr_en, m_wr_valid;
  logic [10:0] m_rpc, m_wr_pc, m_wr_tgt;
  bit          chk_on = 0;

  always @(posedge clk) begin
    bit mis, fl;
    wreq_t w;
    mis = resolve_valid && (resolve_taken ? (!pred_hit || pred_target != resolve_target) : pred_hit);
    if (!rst_n) begin
      m_left = 64; m_idx = 0; m_drops = 0; pend.delete();
      m_redirect = 0; m_rpc = 0; m_wr_en = 0; m_busy = 1;
    end else begin
      m_redirect = mis;
      if (mis) m_rpc = resolve_taken ? resolve_target : 11'((int'(resolve_pc) + 1) % 2048);
      fl = flush_btb && (m_left == 0);
      if (fl) begin pend.delete(); m_left = 64; m_idx = 0; end
      if (m_left > 0) begin
        m_wr_en = 1; m_wr_pc = 11'(m_idx); m_wr_tgt = 0; m_wr_valid = 0;
        m_idx++; m_left--; m_busy = 1;
      end else begin
        m_busy  = 0;
        m_wr_en = (pend.size() > 0);
        if (m_wr_en) begin
          w = pend.pop_front();
          m_wr_pc = w.pc; m_wr_tgt = w.tgt; m_wr_valid = w.v;
        end
      end
      if (mis && !fl) begin
        w.pc = resolve_pc; w.tgt = resolve_taken ? resolve_target : 11'd0; w.v = resolve_taken;
        if (pend.size() < 4) pend.push_back(w);
        else if (m_drops < 255) m_drops++;
      end
    end
  end

  always @(negedge clk) if (chk_on) begin
    chk("m_redirect", 32'(redirect), 32'(m_redirect));
    if (m_redirect) chk("m_redirect_pc", 32'(redirect_pc), 32'(m_rpc));
    chk("m_wr_en", 32'(btb_wr_en), 32'(m_wr_en));
    if (m_wr_en) begin
      chk("m_wr_pc", 32'(btb_wr_pc), 32'(m_wr_pc));
      chk("m_wr_target", 32'(btb_wr_target), 32'(m_wr_tgt));
      chk("m_wr_valid", 32'(btb_wr_valid), 32'(m_wr_valid));
    end
    chk("m_busy", 32'(busy), 32'(m_busy));
    chk("m_drop_cnt", 32'(drop_cnt), 32'(m_drops));
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle();
    resolve_valid = 0; resolve_taken = 0; pred_hit = 0; flush_btb = 0;
    resolve_pc = 0; resolve_target = 0; pred_target = 0;
  endtask

  task automatic resolve(input logic [10:0] pc, input logic tk, input logic [10:0] tgt,
                         input logic hit, input logic [10:0] ptgt);
    resolve_valid = 1; resolve_pc = pc; resolve_taken = tk;
    resolve_target = tgt; pred_hit = hit; pred_target = ptgt;
  endtask

  task automatic do_reset();
    idle(); rst_n = 0; step(); step(); rst_n = 1;
  endtask

  task automatic wait_not_busy(input string name);
    int n;
    for (n = 0; n < 100 && busy; n++) step();
    if (busy) chk({name, "_timeout"}, 32'(busy), 32'd0);
  endtask

  typedef struct {
    logic [10:0] pc; logic tk; logic [10:0] tgt; logic hit; logic [10:0] ptgt;
    logic e_red; logic [10:0] e_rpc; logic e_wr; logic [10:0] e_wtgt; logic e_wv;
  } vec_t;
  vec_t vt[6];

  initial begin
    int sweep_cnt, leak;
    vt[0] = '{11'h123, 1, 11'h200, 0, 11'h000, 1, 11'h200, 1, 11'h200, 1};
    vt[1] = '{11'h7FF, 0, 11'h000, 1, 11'h055, 1, 11'h000, 1, 11'h000, 0};
    vt[2] = '{11'h040, 1, 11'h300, 1, 11'h300, 0, 11'h000, 0, 11'h000, 0};
    vt[3] = '{11'h041, 1, 11'h301, 1, 11'h302, 1, 11'h301, 1, 11'h301, 1};
    vt[4] = '{11'h050, 0, 11'h444, 0, 11'h444, 0, 11'h000, 0, 11'h000, 0};
    vt[5] = '{11'h3FF, 1, 11'h000, 0, 11'h000, 1, 11'h000, 1, 11'h000, 1};

    idle(); rst_n = 0;
    step(); step(); step();
    chk_on = 1;
    chk("rst_busy", 32'(busy), 32'd1);
    chk("rst_redirect_pc", 32'(redirect_pc), 32'd0);
    chk("rst_wr_pc", 32'(btb_wr_pc), 32'd0);
    chk("rst_wr_en", 32'(btb_wr_en), 32'd0);

    // post-reset sweep
    rst_n = 1;
    for (int i = 0; i < 64; i++) begin
      step();
      chk("sweep_en", 32'(btb_wr_en), 32'd1);
      chk("sweep_pc", 32'(btb_wr_pc), 32'(i));
    end
    chk("sweep_busy_last", 32'(busy), 32'd1);
    step();
    chk("sweep_busy_fall", 32'(busy), 32'd0);
    chk("sweep_en_off", 32'(btb_wr_en), 32'd0);

    // vector table, RUN with empty FIFO
    for (int i = 0; i < 6; i++) begin
      resolve(vt[i].pc, vt[i].tk, vt[i].tgt, vt[i].hit, vt[i].ptgt);
      step(); idle();
      chk("vec_redirect", 32'(redirect), 32'(vt[i].e_red));
      if (vt[i].e_red) chk("vec_redirect_pc", 32'(redirect_pc), 32'(vt[i].e_rpc));
      step();
      chk("vec_redirect_off", 32'(redirect), 32'd0);
      chk("vec_wr_en", 32'(btb_wr_en), 32'(vt[i].e_wr));
      if (vt[i].e_wr) begin
        chk("vec_wr_pc", 32'(btb_wr_pc), 32'(vt[i].pc));
        chk("vec_wr_target", 32'(btb_wr_target), 32'(vt[i].e_wtgt));
        chk("vec_wr_valid", 32'(btb_wr_valid), 32'(vt[i].e_wv));
      end
      step();
    end

    // back-to-back mispredicts
    resolve(11'h010, 1, 11'h020, 0, 0); step();
    resolve(11'h011, 0, 11'h000, 1, 11'h099); step(); idle();
    chk("b2b_red1", 32'(redirect), 32'd1);
    chk("b2b_rpc1", 32'(redirect_pc), 32'h012);
    step();
    chk("b2b_red_off", 32'(redirect), 32'd0);
    repeat (3) step();

    // overflow while sweeping
    do_reset();
    repeat (10) step();
    for (int k = 0; k < 6; k++) begin
      resolve(11'(11'h600 + k), 1, 11'(11'h100 + k), 0, 0);
      step();
    end
    idle();
    chk("ovf_drop_cnt", 32'(drop_cnt), 32'd2);
    wait_not_busy("ovf");
    for (int k = 0; k < 4; k++) begin
      chk("ovf_drain_en", 32'(btb_wr_en), 32'd1);
      chk("ovf_drain_pc", 32'(btb_wr_pc), 32'(11'h600 + k));
      chk("ovf_drain_tgt", 32'(btb_wr_target), 32'(11'h100 + k));
      step();
    end
    chk("ovf_drain_done", 32'(btb_wr_en), 32'd0);

    // flush with three queued writes and a simultaneous mispredict
    do_reset();
    repeat (5) step();
    for (int k = 0; k < 3; k++) begin
      resolve(11'(11'h5A0 + k), 1, 11'h222, 0, 0);
      step();
    end
    idle();
    for (int n = 0; n < 100 && !(btb_wr_en && btb_wr_pc == 11'h03F); n++) step();
    if (!(btb_wr_en && btb_wr_pc == 11'h03F)) chk("flush_wait_timeout", 32'(btb_wr_pc), 32'h03F);
    flush_btb = 1;
    resolve(11'h5A3, 1, 11'h111, 0, 0);
    step(); idle();
    chk("flush_redirect", 32'(redirect), 32'd1);
    chk("flush_redirect_pc", 32'(redirect_pc), 32'h111);
    chk("flush_busy", 32'(busy), 32'd1);
    sweep_cnt = 0; leak = 0;
    for (int n = 0; n < 80; n++) begin
      if (btb_wr_en && !btb_wr_valid && btb_wr_target == 0) sweep_cnt++;
      if (btb_wr_en && btb_wr_pc >= 11'h5A0 && btb_wr_pc <= 11'h5A3) leak++;
      step();
    end
    chk("flush_sweep_cnt", 32'(sweep_cnt), 32'd64);
    chk("flush_leak", 32'(leak), 32'd0);

    // random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      resolve_valid  = ($urandom_range(0, 1) == 1);
      resolve_pc     = 11'($urandom);
      resolve_taken  = ($urandom_range(0, 1) == 1);
      resolve_target = 11'($urandom);
      pred_hit       = ($urandom_range(0, 1) == 1);
      pred_target    = ($urandom_range(0, 2) == 0) ? 11'($urandom) : resolve_target;
      flush_btb      = ($urandom_range(0, 149) == 0);
      rst_n          = ($urandom_range(0, 399) != 0);
      step();
    end
    idle(); rst_n = 1;
    repeat (4) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
